// File: rtl/text_buffer.sv
// ---------------------------------------------------------------------------
// text_buffer
//   1024 x 8-bit character store holding the terminal screen image
//   (40 columns per row, row r / column c at address 40*r + c).
//   After reset is released the whole array is swept to ASCII space (0x20)
//   before any external access is accepted, so the screen starts blank.
//
// Ports
//   clk    : rising-edge clock for all state
//   rst    : asynchronous, active-low reset
//   wen    : write enable (ignored while busy)
//   addr   : word address 0..1023 for both read and write
//   wdata  : write data
//   rdata  : registered read data, 1-cycle latency, read-before-write
//   busy   : high while the post-reset clear sweep runs
// ---------------------------------------------------------------------------
module text_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [9:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy
);

  localparam int              DATA_W = 8;
  localparam int              ADDR_W = 10;
  localparam int              DEPTH  = 1024;
  localparam logic [DATA_W-1:0] BLANK  = 8'h20;
  localparam logic [ADDR_W-1:0] LAST   = 10'd1023;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic [ADDR_W-1:0]   sweep_cnt_nxt;
  logic                busy_nxt;

  // Single write port shared between the clear sweep and external writes.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_p1;

  // -------------------------------------------------------------------------
  // Control state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      busy      <= busy_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and write-port steering
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    busy_nxt      = 1'b0;
    mem_we        = 1'b0;
    mem_wa        = addr;
    mem_wd        = wdata;

    case (state)
      ST_CLEAR: begin
        // External inputs are ignored; the sweep owns the write port.
        mem_we        = 1'b1;
        mem_wa        = sweep_cnt;
        mem_wd        = BLANK;
        sweep_cnt_nxt = sweep_cnt + 10'd1;
        if (sweep_cnt == LAST) begin
          // Busy drops on the same edge that writes the last word, so the
          // first external access lands on the following edge.
          state_nxt = ST_READY;
          busy_nxt  = 1'b0;
        end else begin
          busy_nxt  = 1'b1;
        end
      end
      ST_READY: begin
        mem_we   = wen;
        busy_nxt = 1'b0;
      end
      default: begin
        state_nxt = ST_CLEAR;
        busy_nxt  = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage p0 -> p1 : array write and registered read
  // -------------------------------------------------------------------------
  // Storage carries no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Non-blocking update of mem gives read-before-write on a collision:
  // rd_p1 samples the old word on the same edge the new one is stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1 <= '0;
    end else if (state == ST_READY) begin
      rd_p1 <= mem[addr];
    end else begin
      rd_p1 <= '0;
    end
  end

  assign rdata = rd_p1;

endmodule

// File: tb/tb_text_buffer.sv
// ---------------------------------------------------------------------------
// tb_text_buffer
//   Directed bench for text_buffer. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle from the active
//   rising edge.
// ---------------------------------------------------------------------------
module tb_text_buffer;

  logic       clk;
  logic       rst;
  logic       wen;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;

  int n_chk;
  int n_pass;
  int cyc;

  text_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a read at the falling edge; result is valid one edge later.
  task automatic rd(input logic [9:0] a, input logic [7:0] exp, input string tag);
    wen  = 1'b0;
    addr = a;
    @(negedge clk);
    check(tag, {8'h00, rdata}, {8'h00, exp});
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    wen   = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  // Count rising edges from now until busy is seen low (bounded).
  task automatic count_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    wen    = 1'b0;
    addr   = '0;
    wdata  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_rdata", {8'h00, rdata}, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'h0001);

    // Release, let the sweep run, and try to write addr 10 late in the sweep
    rst = 1'b1;
    cyc = 0;
    repeat (600) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_mid_sweep", {15'd0, busy}, 16'h0001);
    check("rdata_mid_sweep", {8'h00, rdata}, 16'h0000);
    wen   = 1'b1;
    addr  = 10'd10;
    wdata = 8'h55;
    while (busy === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    wen = 1'b0;
    check("sweep_len", cyc[15:0], 16'd1024);
    check("busy_after_sweep", {15'd0, busy}, 16'h0000);

    // Blank screen after the sweep
    rd(10'd0,    8'h20, "blank_0");
    rd(10'd288,  8'h20, "blank_288");
    rd(10'd1023, 8'h20, "blank_1023");
    rd(10'd10,   8'h20, "busy_write_ignored");

    // Write then read back, neighbours untouched
    wr(10'd288, 8'h41);
    rd(10'd288, 8'h41, "wr_288");
    rd(10'd287, 8'h20, "nbr_287");
    rd(10'd289, 8'h20, "nbr_289");

    // Collision returns the old contents, new data visible next read
    wen   = 1'b1;
    addr  = 10'd5;
    wdata = 8'h7A;
    @(negedge clk);
    wen = 1'b0;
    check("collision_old", {8'h00, rdata}, 16'h0020);
    rd(10'd5, 8'h7A, "collision_new");

    // Back-to-back writes of addr[7:0] everywhere, then streaming reads
    for (int i = 0; i < 1024; i++) begin
      wen   = 1'b1;
      addr  = 10'(i);
      wdata = 8'(i);
      @(negedge clk);
    end
    wen  = 1'b0;
    addr = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      check($sformatf("stream_%0d", i), {8'h00, rdata}, {8'h00, 8'(i)});
      addr = 10'(i + 1);
    end

    // Mid-operation reset: rdata clears asynchronously
    wr(10'd0, 8'h33);
    rd(10'd0, 8'h33, "wr_0");
    #2 rst = 1'b0;
    #1;
    check("async_rst_rdata", {8'h00, rdata}, 16'h0000);
    check("async_rst_busy", {15'd0, busy}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;

    // Reset again partway through the sweep; the sweep restarts in full
    repeat (500) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_sweep_rst_busy", {15'd0, busy}, 16'h0001);
    check("mid_sweep_rst_rdata", {8'h00, rdata}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    count_sweep(cyc);
    check("resweep_len", cyc[15:0], 16'd1024);
    rd(10'd0, 8'h20, "resweep_addr0");
    rd(10'd288, 8'h20, "resweep_addr288");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
